// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - shared state encodings, datapath select codes and key-length helpers
package aes_pkg;

    typedef enum logic [3:0] {
        ST_IDLE              = 4'd0,
        ST_PTEXT_WRITE       = 4'd1,
        ST_KEY_WRITE         = 4'd2,
        ST_COMPUTE_ROUNDKEYS = 4'd3,
        ST_INIT_ADDROUNDKEY  = 4'd4,
        ST_SUBBYTES          = 4'd5,
        ST_SHIFTROWS         = 4'd6,
        ST_MIXCOLUMNS        = 4'd7,
        ST_ADDROUNDKEY       = 4'd8,
        ST_INV_SUBBYTES      = 4'd9,
        ST_INV_SHIFTROWS     = 4'd10,
        ST_INV_MIXCOLUMNS    = 4'd11,
        ST_DONE              = 4'd12,
        ST_CTEXT_READ        = 4'd13
    } state_t;

    localparam logic [3:0] SEL_LOAD           = 4'd0;
    localparam logic [3:0] SEL_SUBBYTES       = 4'd1;
    localparam logic [3:0] SEL_SHIFTROWS      = 4'd2;
    localparam logic [3:0] SEL_MIXCOLUMNS     = 4'd3;
    localparam logic [3:0] SEL_ADDROUNDKEY    = 4'd4;
    localparam logic [3:0] SEL_INV_SUBBYTES   = 4'd5;
    localparam logic [3:0] SEL_INV_SHIFTROWS  = 4'd6;
    localparam logic [3:0] SEL_INV_MIXCOLUMNS = 4'd7;

    function automatic logic [3:0] key_nr(input logic [1:0] key_len);
        case (key_len)
            2'd1:    return 4'd12;
            2'd2:    return 4'd14;
            default: return 4'd10;
        endcase
    endfunction

    function automatic logic [3:0] key_nk(input logic [1:0] key_len);
        case (key_len)
            2'd1:    return 4'd6;
            2'd2:    return 4'd8;
            default: return 4'd4;
        endcase
    endfunction

endpackage

// File: rtl/aes_beat_counter.sv
// rtl/aes_beat_counter.sv - beat counter over one 4x4 state matrix, LANES columns/rows per beat
module aes_beat_counter #(
    parameter int LANES = 1
) (
    input  logic       clock_i,
    input  logic       reset_i,
    input  logic       clear_i,
    output logic [1:0] beat_o,
    output logic       last_o
);
    localparam logic [1:0] LAST_BEAT = 2'(4 / LANES - 1);

    logic [1:0] beat_q, beat_d;

    always_comb begin
        if (clear_i || beat_q == LAST_BEAT) beat_d = 2'd0;
        else                                beat_d = beat_q + 2'd1;
    end

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) beat_q <= 2'd0;
        else         beat_q <= beat_d;
    end

    assign beat_o = beat_q;
    assign last_o = (beat_q == LAST_BEAT);
endmodule

// File: rtl/aes_round_sequencer.sv
// rtl/aes_round_sequencer.sv - AES cipher / inverse-cipher round sequencer driving a matrix datapath
module aes_round_sequencer
    import aes_pkg::*;
#(
    parameter int LANES    = 1,
    parameter int RK_IDX_W = 4
) (
    input  logic                clock_i,
    input  logic                reset_i,
    input  logic                start_write_n_i,
    input  logic                start_read_n_i,
    input  logic [1:0]          key_len_i,
    input  logic                decrypt_i,
    input  logic                abort_i,
    input  logic                key_expand_done_i,
    output logic [3:0]          matrix_in_sel_o,
    output logic                matrix_write_enable_o,
    output logic                input_mat_row_col_o,
    output logic                output_mat_row_col_o,
    output logic [1:0]          input_mat_idx_o,
    output logic [1:0]          output_mat_idx_o,
    output logic                key_start_o,
    output logic [RK_IDX_W-1:0] round_key_idx_o,
    output logic                done_o,
    output logic                busy_o,
    output logic                cfg_err_o,
    output logic [5:0]          dbg_state_o,
    output logic [3:0]          dbg_round_o
);
    state_t     state_q, state_d;
    logic [3:0] round_q, round_d;
    logic [3:0] key_cnt_q, key_cnt_d;
    logic [1:0] key_len_q, key_len_d;
    logic       decrypt_q, decrypt_d;
    logic       cfg_err_q, cfg_err_d;
    logic [1:0] beat, beat_idx;
    logic       last;
    logic [3:0] nr, nk, key_cycles;
    logic       col, idx_en, rk_en;

    assign nr         = key_nr(key_len_q);
    assign nk         = key_nk(key_len_q);
    assign key_cycles = (LANES == 2) ? {1'b0, nk[3:1]} : nk;
    assign beat_idx   = (LANES == 2) ? {beat[0], 1'b0} : beat;

    aes_beat_counter #(.LANES(LANES)) u_beat (
        .clock_i (clock_i),
        .reset_i (reset_i),
        .clear_i (abort_i || (state_d != state_q)),
        .beat_o  (beat),
        .last_o  (last)
    );

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            state_q   <= ST_IDLE;
            round_q   <= 4'd0;
            key_cnt_q <= 4'd0;
            key_len_q <= 2'd0;
            decrypt_q <= 1'b0;
            cfg_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            round_q   <= round_d;
            key_cnt_q <= key_cnt_d;
            key_len_q <= key_len_d;
            decrypt_q <= decrypt_d;
            cfg_err_q <= cfg_err_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        round_d   = round_q;
        key_len_d = key_len_q;
        decrypt_d = decrypt_q;
        cfg_err_d = 1'b0;
        key_cnt_d = (state_q == ST_KEY_WRITE) ? key_cnt_q + 4'd1 : 4'd0;
        if (abort_i) begin
            state_d   = ST_IDLE;
            round_d   = 4'd0;
            key_cnt_d = 4'd0;
        end else begin
            case (state_q)
                ST_IDLE: if (!start_write_n_i) begin
                    if (key_len_i == 2'd3) cfg_err_d = 1'b1;
                    else begin
                        state_d   = ST_PTEXT_WRITE;
                        key_len_d = key_len_i;
                        decrypt_d = decrypt_i;
                        round_d   = 4'd0;
                    end
                end
                ST_PTEXT_WRITE: if (last) state_d = ST_KEY_WRITE;
                ST_KEY_WRITE: if (key_cnt_q == key_cycles - 4'd1) begin
                    state_d   = ST_COMPUTE_ROUNDKEYS;
                    key_cnt_d = 4'd0;
                end
                ST_COMPUTE_ROUNDKEYS: if (key_expand_done_i) begin
                    state_d = ST_INIT_ADDROUNDKEY;
                    round_d = decrypt_q ? nr : 4'd0;
                end
                ST_INIT_ADDROUNDKEY: if (last) begin
                    state_d = decrypt_q ? ST_INV_SHIFTROWS : ST_SUBBYTES;
                    round_d = decrypt_q ? round_q - 4'd1 : 4'd1;
                end
                ST_SUBBYTES:  if (last) state_d = ST_SHIFTROWS;
                // the final encrypt round has no MixColumns
                ST_SHIFTROWS: if (last) state_d = (round_q == nr) ? ST_ADDROUNDKEY : ST_MIXCOLUMNS;
                ST_MIXCOLUMNS: if (last) state_d = ST_ADDROUNDKEY;
                ST_ADDROUNDKEY: if (last) begin
                    if (decrypt_q) state_d = (round_q == 4'd0) ? ST_DONE : ST_INV_MIXCOLUMNS;
                    else if (round_q == nr) state_d = ST_DONE;
                    else begin
                        state_d = ST_SUBBYTES;
                        round_d = round_q + 4'd1;
                    end
                end
                ST_INV_SHIFTROWS: if (last) state_d = ST_INV_SUBBYTES;
                ST_INV_SUBBYTES:  if (last) state_d = ST_ADDROUNDKEY;
                ST_INV_MIXCOLUMNS: if (last) begin
                    state_d = ST_INV_SHIFTROWS;
                    round_d = round_q - 4'd1;
                end
                ST_DONE: if (!start_read_n_i) state_d = ST_CTEXT_READ;
                ST_CTEXT_READ: if (last) begin
                    state_d = ST_IDLE;
                    round_d = 4'd0;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        matrix_in_sel_o       = SEL_LOAD;
        matrix_write_enable_o = 1'b0;
        col                   = 1'b0;
        idx_en                = 1'b0;
        rk_en                 = 1'b0;
        case (state_q)
            ST_PTEXT_WRITE: begin
                matrix_write_enable_o = 1'b1; col = 1'b1; idx_en = 1'b1;
            end
            ST_INIT_ADDROUNDKEY, ST_ADDROUNDKEY: begin
                matrix_in_sel_o = SEL_ADDROUNDKEY;
                matrix_write_enable_o = 1'b1; col = 1'b1; idx_en = 1'b1; rk_en = 1'b1;
            end
            ST_SUBBYTES: begin
                matrix_in_sel_o = SEL_SUBBYTES;
                matrix_write_enable_o = 1'b1; col = 1'b1; idx_en = 1'b1;
            end
            ST_SHIFTROWS: begin
                matrix_in_sel_o = SEL_SHIFTROWS;
                matrix_write_enable_o = 1'b1; idx_en = 1'b1;
            end
            ST_MIXCOLUMNS: begin
                matrix_in_sel_o = SEL_MIXCOLUMNS;
                matrix_write_enable_o = 1'b1; col = 1'b1; idx_en = 1'b1;
            end
            ST_INV_SUBBYTES: begin
                matrix_in_sel_o = SEL_INV_SUBBYTES;
                matrix_write_enable_o = 1'b1; col = 1'b1; idx_en = 1'b1;
            end
            ST_INV_SHIFTROWS: begin
                matrix_in_sel_o = SEL_INV_SHIFTROWS;
                matrix_write_enable_o = 1'b1; idx_en = 1'b1;
            end
            ST_INV_MIXCOLUMNS: begin
                matrix_in_sel_o = SEL_INV_MIXCOLUMNS;
                matrix_write_enable_o = 1'b1; col = 1'b1; idx_en = 1'b1;
            end
            ST_CTEXT_READ: begin
                col = 1'b1; idx_en = 1'b1;
            end
            default: ;
        endcase
    end

    assign input_mat_row_col_o  = col;
    assign output_mat_row_col_o = col;
    assign input_mat_idx_o      = idx_en ? beat_idx : 2'd0;
    assign output_mat_idx_o     = idx_en ? beat_idx : 2'd0;
    assign key_start_o          = (state_q == ST_PTEXT_WRITE) && last;
    assign round_key_idx_o      = rk_en ? RK_IDX_W'(round_q) : '0;
    assign done_o               = (state_q == ST_DONE);
    assign busy_o               = (state_q != ST_IDLE) && (state_q != ST_DONE);
    assign cfg_err_o            = cfg_err_q;
    assign dbg_state_o          = {2'b00, state_q};
    assign dbg_round_o          = round_q;
endmodule

// File: doc/aes_round_sequencer.md
AES_ROUND_SEQUENCER -- requirements
Module: aes_round_sequencer

Interface
REQ-001 Parameter LANES, default 1, number of columns/rows moved per beat; legal values 1 and 2 only; BEATS = 4/LANES.
REQ-002 Parameter RK_IDX_W, default 4, width of the round-key index output.
REQ-003 Ports: clock  in  1  single clock, rising edge.
REQ-004 Ports: reset  in  1  asynchronous, active-high reset.
REQ-005 Ports: start_write_n  in  1  active-low request to begin the load phase; sampled only in IDLE.
REQ-006 Ports: start_read_n  in  1  active-low request to begin ciphertext readout; sampled only in DONE.
REQ-007 Ports: key_len  in  2  0=AES-128 (Nr 10, Nk 4), 1=AES-192 (Nr 12, Nk 6), 2=AES-256 (Nr 14, Nk 8), 3=illegal; latched at start.
REQ-008 Ports: decrypt  in  1  0=cipher, 1=inverse cipher; latched at start.
REQ-009 Ports: abort  in  1  synchronous return to IDLE from any state.
REQ-010 Ports: key_expand_done  in  1  round keys ready.
REQ-011 Ports: matrix_in_sel  out  4  0 load, 1 SubBytes, 2 ShiftRows, 3 MixColumns, 4 AddRoundKey, 5 InvSubBytes, 6 InvShiftRows, 7 InvMixColumns.
REQ-012 Ports: matrix_write_enable  out  1; input_mat_row_col / output_mat_row_col  out  1 each (0 row, 1 column); input_mat_idx / output_mat_idx  out  2 each (first index of the current beat = beat*LANES).
REQ-013 Ports: key_start  out  1; round_key_idx  out  RK_IDX_W; done  out  1; busy  out  1; cfg_err  out  1; dbg_state  out  6; dbg_round  out  4.

Function
REQ-014 States: IDLE, PTEXT_WRITE, KEY_WRITE, COMPUTE_ROUNDKEYS, INIT_ADDROUNDKEY, SUBBYTES, SHIFTROWS, MIXCOLUMNS, ADDROUNDKEY, INV_SUBBYTES, INV_SHIFTROWS, INV_MIXCOLUMNS, DONE, CTEXT_READ.
REQ-015 IDLE, start_write_n low, key_len!=3: latch key_len and decrypt, go to PTEXT_WRITE with beat 0. If key_len==3: pulse cfg_err for 1 cycle and stay in IDLE.
REQ-016 PTEXT_WRITE lasts BEATS cycles with in_sel 0, write_enable 1, column mode. key_start is high on its final beat only.
REQ-017 KEY_WRITE lasts Nk/LANES cycles with write_enable 0, then goes to COMPUTE_ROUNDKEYS, which waits any number of cycles for key_expand_done.
REQ-018 Every processing state lasts BEATS cycles with write_enable 1. Input and output indices equal the beat. SubBytes, MixColumns, AddRoundKey and their inverses use column mode; ShiftRows and InvShiftRows use row mode.
REQ-019 Cipher order: INIT_ADDROUNDKEY (rk 0), then for r=1..Nr: SUBBYTES, SHIFTROWS, MIXCOLUMNS (skipped when r==Nr), ADDROUNDKEY (rk r).
REQ-020 Inverse order: INIT_ADDROUNDKEY (rk Nr), then for r=Nr-1 down to 0: INV_SHIFTROWS, INV_SUBBYTES, ADDROUNDKEY (rk r), INV_MIXCOLUMNS (skipped when r==0).
REQ-021 round_key_idx is valid during every AddRoundKey beat and is 0 otherwise. dbg_round shows the current r.
REQ-022 DONE: done=1, busy=0. start_read_n low moves to CTEXT_READ: BEATS cycles, column reads, write_enable 0, then IDLE. done is 0 in every other state.
REQ-023 busy=1 in every state except IDLE and DONE. start_write_n is ignored while busy.
REQ-024 abort has priority over all transitions. The next cycle is IDLE with beat and round cleared; no write_enable is issued in that cycle.
REQ-025 The beat counter wraps to 0 on every state change. The round counter is 4 bits and never exceeds 14.
REQ-026 Encrypt cycles from COMPUTE_ROUNDKEYS exit to DONE entry = BEATS*(4*Nr). Decrypt cycles are the same.

Reset
REQ-027 While reset is high: state IDLE, counters 0, latched config 0. All outputs are 0, except dbg_state=IDLE.
REQ-028 A reset asserted mid-operation takes effect immediately. No write_enable is issued until a new start.

Structure
REQ-029 A shared package aes_pkg holds the state encodings, the matrix_in_sel codes, and a key_len-to-Nr/Nk function.
REQ-030 One sub-module, aes_beat_counter, provides the beat counter with a last-beat flag, parametrised by LANES.
REQ-031 All outputs are decoded combinationally from registered state; there are no latches.

Verification
REQ-032 LANES=1, key_len 0, encrypt, key_expand_done 3 cycles after COMPUTE entry -> DONE 160 cycles after COMPUTE exit; 10 AddRoundKey groups with rk 1..10; no MixColumns in round 10.
REQ-033 LANES=1, key_len 2, decrypt -> INIT rk 14; AddRoundKey rk 13..0; 13 InvMixColumns groups; DONE after 224 cycles.
REQ-034 LANES=2, key_len 1 -> KEY_WRITE lasts 3 cycles; indices are 0,2; DONE after 96 cycles.
REQ-035 key_len=3 with start -> cfg_err single pulse; state stays IDLE; busy stays 0.
REQ-036 abort during round 5 SHIFTROWS beat 2 -> IDLE next cycle; a new start then completes normally.
REQ-037 reset asserted during MIXCOLUMNS -> all outputs 0 asynchronously; start_read_n while in IDLE is ignored.
